// File: rtl/act_pkg.sv
// act_pkg: shared constants and helpers for the activation interpolation pipe.
// Holds the default ReLU-shaped LUT image and a scalar interpolation reference.
package act_pkg;

   localparam int ACT_DATA_W = 8;
   localparam int ACT_ADDR_W = 4;

   // Entry 0 at bit 0; entries 0..8 are zero, entry k>8 is (k-8)*16
   localparam logic [16*8-1:0] ACT_LUT_INIT = {
      8'd112, 8'd96, 8'd80, 8'd64,
      8'd48, 8'd32, 8'd16, {9{8'd0}}
   };

   function automatic int act_lut_init(
      input int k,
      input int data_w,
      input int addr_w
   );
      int mid;
      mid = 1 << (addr_w - 1);
      if (k <= mid)
         return 0;
      return (k - mid) << (data_w - addr_w);
   endfunction

   function automatic int act_interp(
      input int base,
      input int nxt,
      input int rem,
      input int frac_w
   );
      int prod;
      prod = (nxt - base) * rem;
      return base + (prod >>> frac_w);
   endfunction

endpackage

// File: rtl/act_interp_lane.sv
// act_interp_lane: combinational LUT address split and base/next fetch.
// Offset-binary index keeps the table monotonic in z; no wrap at the top.
module act_interp_lane
   import act_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic [DATA_W-1:0]               z,
   input  logic [(2**ADDR_W)*DATA_W-1:0]   lut,
   output logic [DATA_W-1:0]               base,
   output logic [DATA_W-1:0]               nxt,
   output logic [DATA_W-ADDR_W-1:0]        rem
);

   localparam int FRAC_W = DATA_W - ADDR_W;

   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_n;
   logic              last;

   assign idx   = z[DATA_W-1:FRAC_W] ^ (ADDR_W'(1) << (ADDR_W - 1));
   assign idx_n = idx + ADDR_W'(1);
   assign last  = &idx;
   assign rem   = z[FRAC_W-1:0];

   assign base = lut[idx*DATA_W +: DATA_W];
   assign nxt  = last ? base : lut[idx_n*DATA_W +: DATA_W];

endmodule

// File: rtl/act_interp_pipe.sv
// act_interp_pipe: 3-stage elastic piecewise-linear activation over LANES.
// Define ACT_LUT_WRITE_EN for a run-time writable LUT; else it is constant.
module act_interp_pipe
   import act_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int LANES  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_z,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_a,
   input  logic                    lut_we,
   input  logic [ADDR_W-1:0]       lut_addr,
   input  logic [DATA_W-1:0]       lut_data
);

   localparam int FRAC_W = DATA_W - ADDR_W;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PROD_W = DATA_W + FRAC_W + 2;

   logic [DEPTH*DATA_W-1:0] lut_flat;

`ifdef ACT_LUT_WRITE_EN
   logic [DATA_W-1:0] lut_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++)
            lut_q[k] <= DATA_W'(act_lut_init(k, DATA_W, ADDR_W));
      end else if (lut_we) begin
         lut_q[lut_addr] <= lut_data;
      end
   end

   always_comb begin
      lut_flat = '0;
      for (int k = 0; k < DEPTH; k++)
         lut_flat[k*DATA_W +: DATA_W] = lut_q[k];
   end
`else
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      assign lut_flat[k*DATA_W +: DATA_W] =
         DATA_W'(act_lut_init(k, DATA_W, ADDR_W));
   end

   logic unused_lut;
   assign unused_lut = ^{lut_we, lut_addr, lut_data};
`endif

   logic adv1, adv2, adv3;
   logic s1_valid, s2_valid, s3_valid;

   logic [LANES-1:0][DATA_W-1:0] base_c, next_c;
   logic [LANES-1:0][FRAC_W-1:0] rem_c;
   logic [LANES-1:0][DATA_W-1:0] s1_base, s1_next;
   logic [LANES-1:0][FRAC_W-1:0] s1_rem;
   logic [LANES-1:0][PROD_W-1:0] prod_c, s2_prod;
   logic [LANES-1:0][DATA_W-1:0] s2_base;
   logic [LANES-1:0][DATA_W-1:0] a_c, s3_a;

   // Elastic chain: a stage moves when empty or when its consumer moves
   assign adv3     = !s3_valid || out_ready;
   assign adv2     = !s2_valid || adv3;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DATA_W:0]   diff;
      logic signed [PROD_W-1:0] diff_x;
      logic signed [PROD_W-1:0] rem_x;

      act_interp_lane #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_lane (
         .z    (in_z[l*DATA_W +: DATA_W]),
         .lut  (lut_flat),
         .base (base_c[l]),
         .nxt  (next_c[l]),
         .rem  (rem_c[l])
      );

      assign diff = $signed({s1_next[l][DATA_W-1], s1_next[l]})
                  - $signed({s1_base[l][DATA_W-1], s1_base[l]});
      assign diff_x    = PROD_W'(diff);
      assign rem_x     = PROD_W'(s1_rem[l]);
      assign prod_c[l] = diff_x * rem_x;

      // Result lies between base and next, so truncation is exact
      assign a_c[l] = DATA_W'($signed(s2_base[l])
                    + ($signed(s2_prod[l]) >>> FRAC_W));

      assign out_a[l*DATA_W +: DATA_W] = s3_a[l];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_base  <= '0;
         s1_next  <= '0;
         s1_rem   <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         s1_base  <= base_c;
         s1_next  <= next_c;
         s1_rem   <= rem_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_prod  <= '0;
         s2_base  <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         s2_prod  <= prod_c;
         s2_base  <= s1_base;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid <= 1'b0;
         s3_a     <= '0;
      end else if (adv3) begin
         s3_valid <= s2_valid;
         s3_a     <= a_c;
      end
   end

   assign out_valid = s3_valid;

endmodule

// File: tb/tb_act_interp_pipe.sv
// tb_act_interp_pipe: table vectors, stall/reset sequences and random stream
// against a scoreboard for act_interp_pipe with LANES=2.
module tb_act_interp_pipe;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NL = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [15:0]    in_z = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [15:0]    out_a;
   logic           lut_we = 1'b0;
   logic [3:0]     lut_addr = '0;
   logic [7:0]     lut_data = '0;

   act_interp_pipe #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .LANES  (NL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_z      (in_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .lut_we    (lut_we),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] z;
      logic [15:0] a;
   } vec_t;

   int n_vec  = 0;
   int n_fail = 0;
   int pops   = 0;
   logic [15:0] sb_q[$];
   logic signed [7:0] lut_m [16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 16; k++)
         lut_m[k] = (k <= 8) ? 8'sd0 : 8'((k - 8) * 16);
   endtask

   function automatic logic [7:0] model_lane(input logic [7:0] z);
      int idx, rem, base, nxt, p, a;
      idx  = {~z[7], z[6:4]};
      rem  = int'(z[3:0]);
      base = int'(lut_m[idx]);
      nxt  = (idx == 15) ? base : int'(lut_m[idx+1]);
      p    = (nxt - base) * rem;
      a    = base + (p >>> 4);
      return a[7:0];
   endfunction

   function automatic logic [15:0] model(input logic [15:0] z);
      return {model_lane(z[15:8]), model_lane(z[7:0])};
   endfunction

   // One clock: drive at negedge, score the transfers that the next edge takes
   task automatic step(input logic v, input logic [15:0] z,
                       input logic ordy, input logic use_exp,
                       input logic [15:0] exp_a, output logic acc);
      @(negedge clk);
      out_ready = ordy;
      in_valid  = v;
      in_z      = z;
      #1;
      if (out_valid && out_ready) begin
         pops++;
         if (sb_q.size() == 0)
            chk("spurious_out", 32'(out_valid), 32'd0);
         else
            chk("out_a", 32'(out_a), 32'(sb_q.pop_front()));
      end
      acc = in_valid && in_ready;
      if (acc)
         sb_q.push_back(use_exp ? exp_a : model(z));
`ifdef ACT_LUT_WRITE_EN
      if (lut_we)
         lut_m[lut_addr] = lut_data;
`endif
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, 16'h0, ordy, 1'b0, 16'h0, acc);
   endtask

   task automatic send(input logic [15:0] z, input logic rnd_rdy,
                       input logic use_exp, input logic [15:0] exp_a);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         step(1'b1, z, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1,
              use_exp, exp_a, acc);
         n++;
      end
      if (!acc)
         chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         idle(1'b1);
         n++;
      end
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   vec_t tbl [8];
   logic [15:0] sv [4];

   initial begin
      logic acc;
      int   p0, k;

      tbl[0] = '{16'h25CE, {8'd37, 8'd0}};
      tbl[1] = '{16'h7FFF, {8'd112, 8'd0}};
      tbl[2] = '{16'h8000, {8'd0, 8'd0}};
      tbl[3] = '{16'h103F, {8'd16, 8'd63}};
      tbl[4] = '{16'h605A, {8'd96, 8'd90}};
      tbl[5] = '{16'h0570, {8'd5, 8'd112}};
      tbl[6] = '{16'h7A6F, {8'd112, 8'd111}};
      tbl[7] = '{16'h9CF0, {8'd0, 8'd0}};
      model_reset();

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      p0 = pops;
      step(1'b1, 16'h25CE, 1'b1, 1'b1, {8'd37, 8'd0}, acc);
      chk("lat_accept", 32'(acc), 32'd1);
      idle(1'b1);
      idle(1'b1);
      chk("lat_not_early", 32'(pops), 32'(p0));
      idle(1'b1);
      chk("lat_three", 32'(pops), 32'(p0 + 1));

      for (int i = 0; i < 8; i++)
         send(tbl[i].z, 1'b0, 1'b1, tbl[i].a);
      drain();

      sv[0] = 16'h1020;
      sv[1] = 16'h3040;
      sv[2] = 16'h5060;
      sv[3] = 16'h7F05;
      p0 = pops;
      k  = 0;
      for (int c = 0; c < 5; c++) begin
         step(1'b1, sv[k], 1'b0, 1'b0, 16'h0, acc);
         if (acc) k++;
      end
      chk("stall_accepted", 32'(k), 32'd3);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      for (int n = 0; n < 20 && k < 4; n++) begin
         step(1'b1, sv[k], 1'b1, 1'b0, 16'h0, acc);
         if (acc) k++;
      end
      drain();
      chk("stall_count", 32'(pops - p0), 32'd4);

      @(negedge clk);
      lut_we   = 1'b1;
      lut_addr = 4'd10;
      lut_data = 8'd100;
      idle(1'b1);
      lut_we = 1'b0;
`ifdef ACT_LUT_WRITE_EN
      send(16'h2525, 1'b0, 1'b1, {8'd83, 8'd83});
`else
      send(16'h2525, 1'b0, 1'b1, {8'd37, 8'd37});
`endif
      drain();

      for (int i = 0; i < 3; i++)
         send(16'h2530 + 16'(i), 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 16'h7070, 1'b0, 1'b0, 16'h0, acc);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_a", 32'(out_a), 32'd0);
      in_valid = 1'b0;
      sb_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pops;
      send(16'h2525, 1'b0, 1'b1, {8'd37, 8'd37});
      drain();
      chk("post_rst_count", 32'(pops - p0), 32'd1);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0)
            idle(1'($urandom_range(0, 1)));
         else
            send(16'($urandom), 1'b1, 1'b0, 16'h0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
